nibble_serial_subtractor: RTL and testbench

//  Multi-cycle subtractor: diff = a - b - bin over WIDTH bits, one 4-bit nibble per clock.

---
 rtl/nibble_serial_subtractor_if.sv | 26 ++
 rtl/nibble_serial_subtractor.sv | 126 ++++++++++++
 tb/tb_nibble_serial_subtractor.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/nibble_serial_subtractor_if.sv
// Handshake/bus bundle for nibble_serial_subtractor.
// master: operand producer / result consumer; slave: the subtractor.
interface nibble_serial_subtractor_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, ovf
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, ovf
    );
endinterface

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin, one 4-bit nibble per clock,
// LSB nibble first, through a 4-cell full-adder chain (a + ~b + ~borrow).
// Optional macro SUB_SAT_EN: saturate diff on signed overflow.
module nibble_serial_subtractor #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    nibble_serial_subtractor_if.slave bus
);
    localparam int unsigned NIBBLES = WIDTH / 4;
    localparam int unsigned CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             borrow_q, borrow_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;

    logic [3:0]       a_nib, nb_nib, nib_sum;
    logic [4:0]       carry;
    logic             nib_borrow;
    logic [WIDTH-1:0] diff_new;
    logic             ovf_new;

    // Current nibble through the full-adder chain; carry-in is the inverted borrow.
    always_comb begin
        a_nib    = a_q[{cnt_q, 2'b00} +: 4];
        nb_nib   = ~b_q[{cnt_q, 2'b00} +: 4];
        carry    = '0;
        nib_sum  = '0;
        carry[0] = ~borrow_q;
        for (int unsigned i = 0; i < 4; i++) begin
            nib_sum[i]   = a_nib[i] ^ nb_nib[i] ^ carry[i];
            carry[i + 1] = (a_nib[i] & nb_nib[i]) | (carry[i] & (a_nib[i] ^ nb_nib[i]));
        end
        nib_borrow = ~carry[4];
        diff_new   = diff_q;
        diff_new[{cnt_q, 2'b00} +: 4] = nib_sum;
        ovf_new    = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_new[WIDTH-1] != a_q[WIDTH-1]);
    end

    // Next-state and datapath updates for IDLE -> RUN -> DONE -> IDLE.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        ovf_d    = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d      = bus.a;
                    b_d      = bus.b;
                    borrow_d = bus.bin;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                diff_d   = diff_new;
                borrow_d = nib_borrow;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    bout_d  = nib_borrow;
                    ovf_d   = ovf_new;
`ifdef SUB_SAT_EN
                    if (ovf_new) begin
                        diff_d = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                              : {1'b0, {(WIDTH-1){1'b1}}};
                    end
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.diff      = diff_q;
    assign bus.bout      = bout_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Scoreboard bench for nibble_serial_subtractor (WIDTH=32).
module tb_nibble_serial_subtractor;
    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    nibble_serial_subtractor_if #(.WIDTH(W)) bus ();

    nibble_serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] diff;
        logic        bout;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: compare each presented result at the cycle it is handed off.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got diff 0x%08h expected none", bus.diff);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("diff", bus.diff, e.diff);
                check("bout", {31'd0, bus.bout}, {31'd0, e.bout});
                check("ovf",  {31'd0, bus.ovf},  {31'd0, e.ovf});
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (!bus.in_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.in_ready) check("idle_timeout", {31'd0, bus.in_ready}, 32'd1);
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic bin,
                        input logic [31:0] ed, input logic eb, input logic eo,
                        input string name);
        int n = 0;
        wait_idle();
        bus.a = a;
        bus.b = b;
        bus.bin = bin;
        bus.in_valid = 1'b1;
        sb.push_back('{diff: ed, bout: eb, ovf: eo});
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        while (!bus.out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_latency"}, n, 32'd8);
    endtask

    logic [31:0] sat3, sat4;

    initial begin
`ifdef SUB_SAT_EN
        sat3 = 32'h8000_0000;
        sat4 = 32'h7FFF_FFFF;
`else
        sat3 = 32'h7FFF_FFFF;
        sat4 = 32'h8000_0000;
`endif
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.bin = 1'b0;
        bus.out_ready = 1'b1;
        #2;
        check("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_diff", bus.diff, 32'd0);
        check("rst_bout", {31'd0, bus.bout}, 32'd0);
        check("rst_ovf",  {31'd0, bus.ovf},  32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        send(32'd5, 32'd3, 1'b0, 32'h2, 1'b0, 1'b0, "t1");
        send(32'd5, 32'd3, 1'b1, 32'h1, 1'b0, 1'b0, "t1b");
        send(32'd0, 32'd1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, "t2");
        send(32'h8000_0000, 32'd1, 1'b0, sat3, 1'b0, 1'b1, "t3");
        send(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, sat4, 1'b1, 1'b1, "t4");
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, "t_eqbin");

        // Back-pressure: hold the result while inputs churn.
        wait_idle();
        bus.out_ready = 1'b0;
        send(32'h0000_FFFF, 32'h0001_0000, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, "t5");
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = ~bus.in_valid;
            bus.a = $urandom;
            bus.b = $urandom;
            @(posedge clk); #1;
            check("bp_diff", bus.diff, 32'hFFFF_FFFF);
            check("bp_bout", {31'd0, bus.bout}, 32'd1);
            check("bp_ovf",  {31'd0, bus.ovf},  32'd0);
            check("bp_in_ready",  {31'd0, bus.in_ready},  32'd0);
            check("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_in_ready",  {31'd0, bus.in_ready},  32'd1);
        check("bp_release_out_valid", {31'd0, bus.out_valid}, 32'd0);

        // Reset in RUN with three nibbles already processed.
        wait_idle();
        bus.a = 32'hFFFF_FFFF;
        bus.b = 32'h0000_0001;
        bus.bin = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("abort_diff", bus.diff, 32'd0);
        check("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk); #1 rst_n = 1'b1;

        send(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h0123_4567, 1'b0, 1'b0, "t6");
        wait_idle();
        check("sb_empty", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
